lsu_align_ctrl: RTL
===================

Name: lsu_align_ctrl

Overview:
Parametrised load/store alignment and memory-handshake unit for the RV32I/RV64I datapath, sitting between the execute stage and the data-memory port. It accepts a load or store with its RISC-V funct3 code and byte address, and drives a word-aligned memory request with byte enables and lane-replicated write data. For loads it extracts and sign- or zero-extends the addressed lane. It flags misaligned or illegal accesses without touching memory.

Parameters:
XLEN, 32, datapath and memory word width; legal values are 32 and 64. NB = XLEN/8 byte lanes; OFS_W = log2(NB).
ADDR_W, 32, byte-address width.

Ports:
clk  in  1  the single clock
reset  in  1  synchronous, active-high reset
req_valid  in  1  a request is offered
req_ready  out  1  unit can accept (high only in IDLE)
req_we  in  1  1 = store, 0 = load
req_funct3  in  3  RISC-V size/sign code: 000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU
req_addr  in  ADDR_W  byte address
req_wdata  in  XLEN  store data, least-significant bits used
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  XLEN  extended load data; 0 for stores and errors
resp_misalign  out  1  qualifies resp_valid: address not aligned to access size
resp_illegal  out  1  qualifies resp_valid: funct3 illegal for XLEN/direction
mem_req  out  1  memory request, held until granted
mem_we  out  1  memory write
mem_addr  out  ADDR_W  req_addr with low OFS_W bits cleared
mem_be  out  NB  byte enables
mem_wdata  out  XLEN  lane-replicated store data
mem_gnt  in  1  memory accepts mem_req
mem_rvalid  in  1  load data valid
mem_rdata  in  XLEN  load data word
busy  out  1  state != IDLE

Behaviour:
- FSM states: IDLE, REQ, WAIT, RESP. All outputs are registered or decoded from state and registered fields.
- Reset (any state, including mid-transaction) forces IDLE. All outputs are 0 except req_ready=1. An outstanding mem_req is dropped. A later mem_rvalid is ignored.
- IDLE: on req_valid, latch we, funct3, addr, wdata.
  - Illegal funct3 (011 or 110 when XLEN=32; 110 or 111 on a store; 111 always) goes to RESP with resp_illegal=1.
  - Otherwise, misaligned (H with addr[0]!=0, W with addr[1:0]!=0, D with addr[2:0]!=0) goes to RESP with resp_misalign=1.
  - Otherwise go to REQ.
  - If both checks fail, only illegal is reported.
- REQ: mem_req=1 with stable mem_addr, mem_we, mem_be, mem_wdata.
  - On mem_gnt, a store goes to RESP and a load goes to WAIT.
  - With no grant, stay in REQ indefinitely.
- WAIT: on mem_rvalid, register the extended data and go to RESP. mem_rvalid is sampled only in WAIT.
- RESP: resp_valid=1 for exactly one cycle, then IDLE. There is no response back-pressure.
- Byte enables: size mask (B=1, H=3, W=0xF, D=0xFF) shifted left by offset = addr[OFS_W-1:0].
- Write data: B replicates byte 0 across NB lanes; H replicates the halfword; W replicates the word (XLEN=64); D passes through.
- Load extract: shift mem_rdata right by offset*8 and take the low size bytes.
  - B, H, W sign-extend from the top bit of the size.
  - BU, HU, WU zero-extend.
- Latency with mem_gnt asserted immediately and mem_rvalid one cycle after grant:
  - Store: request in cycle 0, resp_valid in cycle 2.
  - Load: request in cycle 0, resp_valid in cycle 3.
  - Error: request in cycle 0, resp_valid in cycle 1.
- A new request can be accepted in the cycle after RESP.

Decomposition:
- lsu_pkg holds:
  - the funct3 enum (LS_B, LS_H, LS_W, LS_D, LS_BU, LS_HU, LS_WU);
  - the state enum;
  - constant size masks;
  - function size_bytes(funct3);
  - function is_legal(funct3, we, xlen).
- One combinational sub-module, lsu_load_extract (parameter XLEN; inputs rdata, offset, funct3; output extended data), instantiated once in the WAIT data path.

Test Plan:
- XLEN=32, load LB at addr 0x1003, mem_rdata=0x80FF_1234, immediate gnt and rvalid next cycle -> mem_addr=0x1000, mem_be=4'b1000, resp_rdata=0xFFFF_FF80, resp_valid in cycle 3.
- XLEN=32, store SH at 0x2002 with wdata=0xDEAD_BEEF -> mem_be=4'b1100, mem_wdata=0xBEEF_BEEF, mem_we=1, resp_valid in cycle 2 with resp_rdata=0.
- XLEN=32, LW at 0x3001 -> no mem_req ever asserted, resp_valid in cycle 1 with resp_misalign=1; funct3=011 -> resp_illegal=1, resp_misalign=0.
- XLEN=64, LWU at 0x4004, mem_rdata=0x8765_4321_0000_0000 -> mem_be=8'hF0, resp_rdata=0x0000_0000_8765_4321.
- mem_gnt held low 5 cycles -> mem_req and all mem_* fields stable for 6 cycles, req_ready=0 and busy=1 throughout.
- Load granted, reset asserted in WAIT, then mem_rvalid pulses -> outputs cleared the cycle after reset, no resp_valid, req_ready=1, and the next LBU at 0x0 returns a correct zero-extended byte.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and decode helpers for the load/store alignment unit.
package lsu_pkg;

  typedef enum logic [2:0] {
    LS_B  = 3'b000,
    LS_H  = 3'b001,
    LS_W  = 3'b010,
    LS_D  = 3'b011,
    LS_BU = 3'b100,
    LS_HU = 3'b101,
    LS_WU = 3'b110
  } ls_funct3_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } lsu_state_e;

  localparam logic [7:0] MASK_B = 8'h01;
  localparam logic [7:0] MASK_H = 8'h03;
  localparam logic [7:0] MASK_W = 8'h0F;
  localparam logic [7:0] MASK_D = 8'hFF;

  function automatic logic [3:0] size_bytes(input logic [2:0] funct3);
    case (funct3)
      LS_B, LS_BU: size_bytes = 4'd1;
      LS_H, LS_HU: size_bytes = 4'd2;
      LS_W, LS_WU: size_bytes = 4'd4;
      LS_D:        size_bytes = 4'd8;
      default:     size_bytes = 4'd0;
    endcase
  endfunction

  function automatic logic [7:0] size_mask(input logic [2:0] funct3);
    case (funct3)
      LS_B, LS_BU: size_mask = MASK_B;
      LS_H, LS_HU: size_mask = MASK_H;
      LS_W, LS_WU: size_mask = MASK_W;
      LS_D:        size_mask = MASK_D;
      default:     size_mask = 8'h00;
    endcase
  endfunction

  // 111 is never legal; D and WU need a 64-bit datapath; WU has no store form.
  function automatic logic is_legal(input logic [2:0] funct3, input logic we, input int xlen);
    is_legal = 1'b1;
    if (funct3 == 3'b111) is_legal = 1'b0;
    if ((xlen == 32) && ((funct3 == LS_D) || (funct3 == LS_WU))) is_legal = 1'b0;
    if (we && (funct3 == LS_WU)) is_legal = 1'b0;
  endfunction

endpackage

// File: rtl/lsu_load_extract.sv
// Selects the addressed lane of a memory word and sign- or zero-extends it.
module lsu_load_extract
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0]         rdata,
  input  logic [$clog2(XLEN/8)-1:0] offset,
  input  logic [2:0]              funct3,
  output logic [XLEN-1:0]         data
);

  logic [XLEN-1:0] sh;
  logic [XLEN-1:0] keep;
  logic [3:0]      size;
  logic            sgn;

  assign sh   = rdata >> {offset, 3'b000};
  assign size = size_bytes(funct3);

  // keep covers the bytes of the access; everything above is fill
  always_comb begin
    keep = '0;
    for (int i = 0; i < XLEN/8; i++) begin
      keep[i*8 +: 8] = {8{(4'(i) < size)}};
    end
  end

  always_comb begin
    sgn = 1'b0;
    case (funct3)
      LS_B:    sgn = sh[7];
      LS_H:    sgn = sh[15];
      LS_W:    sgn = sh[31];
      default: sgn = 1'b0;
    endcase
  end

  assign data = (sh & keep) | ({XLEN{sgn}} & ~keep);

endmodule

// File: rtl/lsu_align_ctrl.sv
// Load/store alignment and data-memory handshake controller.
//
// state | meaning
// IDLE  | ready for a request; fields latched on req_valid
// REQ   | mem_req held with stable fields until mem_gnt
// WAIT  | load granted, waiting for mem_rvalid
// RESP  | one-cycle resp_valid pulse
module lsu_align_ctrl
  import lsu_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [2:0]          req_funct3,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [XLEN-1:0]     req_wdata,
  output logic                resp_valid,
  output logic [XLEN-1:0]     resp_rdata,
  output logic                resp_misalign,
  output logic                resp_illegal,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [XLEN/8-1:0]   mem_be,
  output logic [XLEN-1:0]     mem_wdata,
  input  logic                mem_gnt,
  input  logic                mem_rvalid,
  input  logic [XLEN-1:0]     mem_rdata,
  output logic                busy
);

  localparam int NB    = XLEN / 8;
  localparam int OFS_W = $clog2(NB);

  lsu_state_e        state_q, state_d;
  logic              we_q;
  logic [2:0]        f3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [XLEN-1:0]   wdata_q;
  logic [XLEN-1:0]   rdata_q;
  logic              misalign_q, illegal_q;

  logic              req_legal, req_misalign;
  logic [XLEN-1:0]   ext_data;
  logic [NB-1:0]     be_mask, be_calc;
  logic [XLEN-1:0]   wdata_calc;

  assign req_legal = is_legal(req_funct3, req_we, XLEN);

  always_comb begin
    req_misalign = 1'b0;
    case (req_funct3)
      LS_H, LS_HU: req_misalign = req_addr[0];
      LS_W, LS_WU: req_misalign = |req_addr[1:0];
      LS_D:        req_misalign = |req_addr[2:0];
      default:     req_misalign = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (req_valid) state_d = (!req_legal || req_misalign) ? ST_RESP : ST_REQ;
      ST_REQ:  if (mem_gnt)   state_d = we_q ? ST_RESP : ST_WAIT;
      ST_WAIT: if (mem_rvalid) state_d = ST_RESP;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      we_q       <= 1'b0;
      f3_q       <= 3'b000;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      misalign_q <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      if ((state_q == ST_IDLE) && req_valid) begin
        we_q       <= req_we;
        f3_q       <= req_funct3;
        addr_q     <= req_addr;
        wdata_q    <= req_wdata;
        rdata_q    <= '0;
        illegal_q  <= !req_legal;
        misalign_q <= req_legal && req_misalign;
      end
      if ((state_q == ST_WAIT) && mem_rvalid) rdata_q <= ext_data;
    end
  end

  lsu_load_extract #(.XLEN(XLEN)) u_extract (
    .rdata  (mem_rdata),
    .offset (addr_q[OFS_W-1:0]),
    .funct3 (f3_q),
    .data   (ext_data)
  );

  assign be_mask = NB'(size_mask(f3_q));
  assign be_calc = be_mask << addr_q[OFS_W-1:0];

  // replicate the store operand so every lane carries it; memory picks by mem_be
  always_comb begin
    case (f3_q)
      LS_B, LS_BU: wdata_calc = {NB{wdata_q[7:0]}};
      LS_H, LS_HU: wdata_calc = {(NB/2){wdata_q[15:0]}};
      LS_W, LS_WU: wdata_calc = {(NB/4){wdata_q[31:0]}};
      default:     wdata_calc = wdata_q;
    endcase
  end

  always_comb begin
    req_ready     = (state_q == ST_IDLE);
    busy          = (state_q != ST_IDLE);
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    mem_addr      = '0;
    mem_be        = '0;
    mem_wdata     = '0;
    resp_valid    = 1'b0;
    resp_rdata    = '0;
    resp_misalign = 1'b0;
    resp_illegal  = 1'b0;
    case (state_q)
      ST_REQ: begin
        mem_req   = 1'b1;
        mem_we    = we_q;
        mem_addr  = {addr_q[ADDR_W-1:OFS_W], {OFS_W{1'b0}}};
        mem_be    = be_calc;
        mem_wdata = wdata_calc;
      end
      ST_RESP: begin
        resp_valid    = 1'b1;
        resp_rdata    = rdata_q;
        resp_misalign = misalign_q;
        resp_illegal  = illegal_q;
      end
      default: ;
    endcase
  end

endmodule
